mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the CPU instruction-fetch port and the load/store port.
- Sits between `cpu` and the memory model.
- Serialises accesses, tracks a fixed memory latency and returns registered read data and completion pulses.
- Drives a stall signal that freezes the CPU while any access is outstanding.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_arb2.sv | 77 +++++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_e      : arbiter FSM states (IDLE, WAIT, RESP)
//   REQ_IF/REQ_D : requester IDs; also the bit positions in the one-hot grant
//   req_onehot() : converts a requester ID into its one-hot grant vector
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    function automatic logic [1:0] req_onehot(input logic id);
        logic [1:0] oh;
        oh     = 2'b00;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb2.sv
// arb2: two-way request arbiter producing a one-hot grant (bit REQ_IF / REQ_D).
//   en      in  arbitration allowed this cycle (FSM in IDLE or RESP, not in reset)
//   if_req  in  fetch request
//   d_req   in  data request
//   gnt     out one-hot grant, 2'b00 when nothing is granted
// Build option MEM_ARB_RR_EN: round-robin on ties using a last-winner flag
// (clk/rst_n ports exist only in that build). Without it: data beats fetch.
module arb2
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       en,
    input  logic       if_req,
    input  logic       d_req,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    // Grant selection: on a tie the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (d_req && if_req) begin
            gnt = (last_q == REQ_D) ? req_onehot(REQ_IF) : req_onehot(REQ_D);
        end else if (d_req) begin
            gnt = req_onehot(REQ_D);
        end else if (if_req) begin
            gnt = req_onehot(REQ_IF);
        end else begin
            gnt = 2'b00;
        end
    end

    // Last-winner next value: only moves when a grant is actually issued.
    always_comb begin
        last_d = last_q;
        if (gnt[REQ_D]) begin
            last_d = REQ_D;
        end else if (gnt[REQ_IF]) begin
            last_d = REQ_IF;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner flag; resets to "fetch last" so data wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: data beats fetch.
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (d_req) begin
            gnt = req_onehot(REQ_D);
        end else if (if_req) begin
            gnt = req_onehot(REQ_IF);
        end else begin
            gnt = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store port. Accesses are serialised; each one is issued
// for exactly one cycle, waits MEM_LAT cycles for mem_rdata, then produces a
// one-cycle completion pulse with registered read data.
// Parameters: ADDR_W, DATA_W, MEM_LAT (>=1, issue-to-data latency).
// Ports:
//   clk, rst_n (async active-low)
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata            fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_done, d_rdata      load/store port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata              memory side
//   cpu_stall                                                freeze the CPU
// Build option MEM_ARB_RR_EN: round-robin arbitration instead of data-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               owner_we_q, owner_we_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               d_done_q, d_done_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

    logic               arb_en_s;
    logic [1:0]         gnt_s;

    // Grants are only legal in IDLE/RESP; rst_n gating keeps the strobes low while in reset.
    assign arb_en_s = rst_n && (state_q != WAIT);

    arb2 u_arb2 (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .en     (arb_en_s),
        .if_req (if_req),
        .d_req  (d_req),
        .gnt    (gnt_s)
    );

    // Next-state, latency counter and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        owner_we_d  = owner_we_q;
        if_rvalid_d = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (gnt_s != 2'b00) begin
                    state_d    = WAIT;
                    cnt_d      = CNT_LOAD;
                    owner_d    = gnt_s[REQ_D] ? REQ_D : REQ_IF;
                    owner_we_d = gnt_s[REQ_D] & d_we;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == REQ_D) begin
                        d_done_d = 1'b1;
                        // Stores complete without touching the load data register.
                        if (!owner_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side drive: winner's command during the grant cycle, all zeros otherwise.
    always_comb begin
        mem_en    = |gnt_s;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_s[REQ_D]) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (gnt_s[REQ_IF]) begin
            mem_addr  = if_addr;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // FSM and response registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_IF;
            owner_we_q  <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            owner_we_q  <= owner_we_d;
            if_rvalid_q <= if_rvalid_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = gnt_s[REQ_IF];
    assign d_gnt     = gnt_s[REQ_D];
    assign if_rvalid = if_rvalid_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign cpu_stall = (if_req & ~if_rvalid_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter.
// dut0 runs with MEM_LAT=2 against a small word memory with a 2-stage read pipe;
// dut1 runs with MEM_LAT=1 against a 1-stage read pipe (data = 0x1000_0000 | addr).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0 (MEM_LAT=2)
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_done, mem_en, mem_we, cpu_stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    // dut1 (MEM_LAT=1)
    logic        if_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
    logic [31:0] if_addr1 = 32'h0, d_addr1 = 32'h0, d_wdata1 = 32'h0, mem_rdata1;
    logic        if_gnt1, if_rvalid1, d_gnt1, d_done1, mem_en1, mem_we1, cpu_stall1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .cpu_stall(cpu_stall1)
    );

    // Memory model for dut0: 64 words, read data appears two cycles after mem_en.
    logic [31:0] mem [0:63];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h2002_000A;   // 0x10
            mem[8]  <= 32'h1234_5678;   // 0x20
            mem[17] <= 32'h0BAD_F00D;   // 0x44
            rd_p0   <= 32'h0;
            rd_p1   <= 32'h0;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            rd_p0 <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'h0;
            rd_p1 <= rd_p0;
        end
    end
    assign mem_rdata = rd_p1;

    // Memory model for dut1: one-cycle read pipe.
    logic [31:0] rd1;
    always @(posedge clk) begin
        rd1 <= (mem_en1 && !mem_we1) ? (32'h1000_0000 | mem_addr1) : 32'h0;
    end
    assign mem_rdata1 = rd1;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_if;   // if_rdata after completion
        logic [31:0] exp_d;    // d_rdata after completion
    } vec_t;

    vec_t vecs [6];

    task automatic check_all_zero(input string tag);
        check1({tag, ".if_gnt"},    if_gnt,    1'b0);
        check1({tag, ".d_gnt"},     d_gnt,     1'b0);
        check1({tag, ".if_rvalid"}, if_rvalid, 1'b0);
        check1({tag, ".d_done"},    d_done,    1'b0);
        check1({tag, ".mem_en"},    mem_en,    1'b0);
        check1({tag, ".mem_we"},    mem_we,    1'b0);
        check32({tag, ".mem_addr"},  mem_addr,  32'h0);
        check32({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        check32({tag, ".if_rdata"},  if_rdata,  32'h0);
        check32({tag, ".d_rdata"},   d_rdata,   32'h0);
        check1({tag, ".cpu_stall"}, cpu_stall, 1'b0);
    endtask

    // One complete access on dut0: grant in the first cycle, pulse 3 cycles later.
    task automatic do_access(input vec_t v, input string tag);
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        check1({tag, ".gnt"}, v.is_d ? d_gnt : if_gnt, 1'b1);
        check1({tag, ".mem_en"}, mem_en, 1'b1);
        check1({tag, ".mem_we"}, mem_we, v.is_d & v.we);
        check32({tag, ".mem_addr"}, mem_addr, v.addr);
        if (v.is_d && v.we) check32({tag, ".mem_wdata"}, mem_wdata, v.wdata);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check1({tag, ".wait_mem_en"}, mem_en, 1'b0);
            check32({tag, ".wait_mem_addr"}, mem_addr, 32'h0);
            check1({tag, ".wait_stall"}, cpu_stall, 1'b1);
            check1({tag, ".wait_pulse"}, if_rvalid | d_done, 1'b0);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check1({tag, ".pulse"}, v.is_d ? d_done : if_rvalid, 1'b1);
        check1({tag, ".other_pulse"}, v.is_d ? if_rvalid : d_done, 1'b0);
        check1({tag, ".resp_mem_en"}, mem_en, 1'b0);
        check32({tag, ".if_rdata"}, if_rdata, v.exp_if);
        check32({tag, ".d_rdata"}, d_rdata, v.exp_d);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        fresh;
        logic [3:0]  exp_w;
        logic [3:0]  got_w;
        int          gcyc [4];
        int          ng;
        int          npulse;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h2002_000A, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h2002_000A, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h2002_000A, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'h2002_000A, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h0BAD_F00D, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h0BAD_F00D, 32'h1234_5678};
        fresh   = '{1'b1, 1'b0, 32'h44, 32'h0,         32'h0,         32'h0BAD_F00D};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single accesses, first one in the first cycle after release
        for (int i = 0; i < 6; i++) do_access(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: data first, fetch granted back-to-back in RESP
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check1("simul.d_gnt", d_gnt, 1'b1);
        check1("simul.if_gnt_t", if_gnt, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check1("simul.d_done", d_done, 1'b1);
        check1("simul.if_gnt_t3", if_gnt, 1'b1);
        check32("simul.mem_addr_t3", mem_addr, 32'h10);
        check32("simul.d_rdata", d_rdata, 32'h1234_5678);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check1("simul.if_rvalid", if_rvalid, 1'b1);
        check32("simul.if_rdata", if_rdata, 32'h2002_000A);

        // Reset during WAIT: everything clears, no completion, fresh grant right after release
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        check1("rstmid.d_gnt", d_gnt, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0; d_req = 1'b0;
        #1;
        check_all_zero("rstmid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check1("rstmid.no_done", d_done, 1'b0);
        end
        rst_n = 1'b1;
        do_access(fresh, "rstmid.fresh");

        // Continuous contention from a clean reset
`ifdef MEM_ARB_RR_EN
        exp_w = 4'b0101;   // bit i = 1 when grant i goes to data: D, IF, D, IF
`else
        exp_w = 4'b1111;   // data always wins
`endif
        apply_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h10;
        ng = 0;
        got_w = 4'b0000;
        for (int c = 0; c < 16 && ng < 4; c++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                check1("contend.onehot", if_gnt & d_gnt, 1'b0);
                got_w[ng] = d_gnt;
                gcyc[ng] = c;
                ng++;
            end
        end
        check32("contend.grants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check1($sformatf("contend.winner%0d", i), got_w[i], exp_w[i]);
            if (i > 0) check32($sformatf("contend.spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
        npulse = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_rvalid || d_done) npulse++;
        end
        check32("contend.drop_completes", 32'(npulse), 32'd1);

        // MEM_LAT=1 instance with cpu_stall
        @(posedge clk); #1;
        if_req1 = 1'b1; if_addr1 = 32'h30;
        @(negedge clk);
        check1("lat1.gnt", if_gnt1, 1'b1);
        check1("lat1.stall_t0", cpu_stall1, 1'b1);
        @(negedge clk);
        check1("lat1.stall_t1", cpu_stall1, 1'b1);
        check1("lat1.rvalid_t1", if_rvalid1, 1'b0);
        @(negedge clk);
        check1("lat1.rvalid_t2", if_rvalid1, 1'b1);
        check1("lat1.stall_t2", cpu_stall1, 1'b0);
        check32("lat1.rdata", if_rdata1, 32'h1000_0030);
        check1("lat1.b2b_gnt", if_gnt1, 1'b1);
        @(posedge clk); #1;
        if_req1 = 1'b0;
        npulse = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if_rvalid1) npulse++;
        end
        check32("lat1.second_pulse", 32'(npulse), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
